sprite_line_buffer: RTL and testbench

//   Double-buffered scanline store downstream of SPRITEGEN. Sprite pixels (DOT + priority) for the

---
 rtl/sprite_line_buffer.sv | 179 +++++++++++++++++
 tb/tb_sprite_line_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite scanline store: priority-resolved writes into the back bank,
// read-and-clear of the front bank in step with the display, bank swap on LINE_START.
module sprite_line_buffer #(
  parameter int unsigned WIDTH       = 288,
  parameter int unsigned XBITS       = 9,
  parameter int unsigned PRI_BITS    = 3,
  parameter logic [7:0]  TRANSPARENT = 8'hFF
) (
  input  logic                CLK_6M,
  input  logic                RESET,
  input  logic                LINE_START,
  input  logic                WR_EN,
  input  logic [XBITS-1:0]    WR_X,
  input  logic [7:0]          WR_DOT,
  input  logic [PRI_BITS-1:0] WR_PRI,
  input  logic                RD_EN,
  output logic [7:0]          DOT,
  output logic [PRI_BITS-1:0] PRI,
  output logic                OPAQUE,
  output logic                BUSY,
  output logic                WR_DROP
);
  localparam logic [XBITS-1:0] X_END  = XBITS'(WIDTH);
  localparam logic [XBITS-1:0] X_LAST = XBITS'(WIDTH - 1);

  typedef struct packed {
    logic [7:0]          dot;
    logic [PRI_BITS-1:0] pri;
  } pix_t;

  typedef struct packed {
    logic             vld;
    logic             bank;
    logic [XBITS-1:0] x;
    pix_t             pix;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             bank;
    logic [XBITS-1:0] x;
    pix_t             pix;
    pix_t             old;
  } s2_t;

  typedef enum logic { ST_CLEAR, ST_RUN } state_t;

  localparam pix_t PIX_EMPTY = '{dot: TRANSPARENT, pri: '0};

  pix_t mem [2][WIDTH];

  state_t           state_q, state_d;
  logic [XBITS-1:0] clr_q, clr_d;
  logic             sel_q, sel_d;
  logic [XBITS-1:0] rcnt_q, rcnt_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  pix_t             out_q, out_d;
  logic             opaque_q, opaque_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  logic clr_we, cm_we, rc_we;
  pix_t s1_old;

  // Control, write pipeline and readout registers.
  always_ff @(posedge CLK_6M) begin
    if (RESET) begin
      state_q  <= ST_CLEAR;
      clr_q    <= '0;
      sel_q    <= 1'b0;
      rcnt_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_q    <= PIX_EMPTY;
      opaque_q <= 1'b0;
      busy_q   <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      sel_q    <= sel_d;
      rcnt_q   <= rcnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_q    <= out_d;
      opaque_q <= opaque_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  // Read-clear is written last so it overrides a late commit to the same front address.
  always_ff @(posedge CLK_6M) begin
    if (!RESET) begin
      if (clr_we) begin
        mem[1'b0][clr_q] <= PIX_EMPTY;
        mem[1'b1][clr_q] <= PIX_EMPTY;
      end
      if (cm_we) mem[s2_q.bank][s2_q.x] <= s2_q.pix;
      if (rc_we) mem[sel_q][rcnt_q] <= PIX_EMPTY;
    end
  end

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    sel_d    = sel_q;
    rcnt_d   = rcnt_q;
    s1_d     = '0;
    s2_d     = '0;
    out_d    = PIX_EMPTY;
    busy_d   = 1'b0;
    drop_d   = 1'b0;
    clr_we   = 1'b0;
    cm_we    = 1'b0;
    rc_we    = 1'b0;
    s1_old   = mem[s1_q.bank][s1_q.x];

    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        busy_d = 1'b1;
        if (clr_q == X_LAST) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end else begin
          clr_d = clr_q + XBITS'(1);
        end
      end

      ST_RUN: begin
        if (LINE_START) begin
          sel_d  = ~sel_q;
          rcnt_d = '0;
        end else if (RD_EN && (rcnt_q < X_END)) begin
          out_d  = mem[sel_q][rcnt_q];
          rc_we  = 1'b1;
          rcnt_d = rcnt_q + XBITS'(1);
        end

        // Accept stage: tag with the back bank as it will be after any swap this cycle.
        if (WR_EN && (WR_DOT != TRANSPARENT)) begin
          if (WR_X >= X_END) begin
            drop_d = 1'b1;
          end else begin
            s1_d.vld     = 1'b1;
            s1_d.bank    = LINE_START ? sel_q : ~sel_q;
            s1_d.x       = WR_X;
            s1_d.pix.dot = WR_DOT;
            s1_d.pix.pri = WR_PRI;
          end
        end

        cm_we = s2_q.vld && ((s2_q.old.dot == TRANSPARENT) || (s2_q.pix.pri >= s2_q.old.pri));

        // Forward the committing value so back-to-back writes resolve serially.
        if (cm_we && (s2_q.bank == s1_q.bank) && (s2_q.x == s1_q.x)) s1_old = s2_q.pix;

        s2_d.vld  = s1_q.vld;
        s2_d.bank = s1_q.bank;
        s2_d.x    = s1_q.x;
        s2_d.pix  = s1_q.pix;
        s2_d.old  = s1_old;
      end

      default: state_d = ST_CLEAR;
    endcase

    opaque_d = (out_d.dot != TRANSPARENT);
  end

  assign DOT     = out_q.dot;
  assign PRI     = out_q.pri;
  assign OPAQUE  = opaque_q;
  assign BUSY    = busy_q;
  assign WR_DROP = drop_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Scoreboard bench for sprite_line_buffer: the driver queues a hand-computed expectation per
// cycle, the monitor pops and compares one entry after every rising edge.
module tb_sprite_line_buffer;
  localparam int unsigned W = 288;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line_start = 1'b0;
  logic       wr_en = 1'b0;
  logic [8:0] wr_x = '0;
  logic [7:0] wr_dot = '0;
  logic [2:0] wr_pri = '0;
  logic       rd_en = 1'b0;
  logic [7:0] dot;
  logic [2:0] pri;
  logic       opaque, busy, wr_drop;

  typedef struct {
    logic [7:0] dot;
    logic [2:0] pri;
    logic       opaque;
    logic       busy;
    logic       drop;
    string      phase;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] line_dot [W];
  logic [2:0] line_pri [W];
  int         busy_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         item = 0;
  string      phase = "init";

  sprite_line_buffer dut (
    .CLK_6M    (clk),
    .RESET     (reset),
    .LINE_START(line_start),
    .WR_EN     (wr_en),
    .WR_X      (wr_x),
    .WR_DOT    (wr_dot),
    .WR_PRI    (wr_pri),
    .RD_EN     (rd_en),
    .DOT       (dot),
    .PRI       (pri),
    .OPAQUE    (opaque),
    .BUSY      (busy),
    .WR_DROP   (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic ls, input logic wen, input logic [8:0] x,
                       input logic [7:0] d, input logic [2:0] p, input logic ren,
                       input logic [7:0] ed, input logic [2:0] ep, input logic edrop);
    exp_t e;
    @(negedge clk);
    reset = rst; line_start = ls; wr_en = wen; wr_x = x; wr_dot = d; wr_pri = p; rd_en = ren;
    if (rst) busy_cnt = W;
    e.busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    e.dot = ed; e.pri = ep; e.opaque = (ed != 8'hFF); e.drop = edrop; e.phase = phase;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 9'd0, 8'h00, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [8:0] x, input logic [7:0] d, input logic [2:0] p, input logic edrop);
    drive(1'b0, 1'b0, 1'b1, x, d, p, 1'b0, 8'hFF, 3'd0, edrop);
  endtask

  task automatic clear_line();
    for (int i = 0; i < W; i++) begin
      line_dot[i] = 8'hFF;
      line_pri[i] = 3'd0;
    end
  endtask

  task automatic read_line(input logic do_ls, input logic ls_ren);
    if (do_ls) drive(1'b0, 1'b1, 1'b0, 9'd0, 8'h00, 3'd0, ls_ren, 8'hFF, 3'd0, 1'b0);
    for (int i = 0; i < W; i++)
      drive(1'b0, 1'b0, 1'b0, 9'd0, 8'h00, 3'd0, 1'b1, line_dot[i], line_pri[i], 1'b0);
    clear_line();
  endtask

  // Reset with every other input active, then sit through the clear sweep poking ignored inputs.
  task automatic reset_seq();
    drive(1'b1, 1'b1, 1'b1, 9'd50, 8'h77, 3'd7, 1'b1, 8'hFF, 3'd0, 1'b0);
    for (int i = 0; i < W; i++) begin
      if (i == 10)      drive(1'b0, 1'b0, 1'b1, 9'd3, 8'h12, 3'd7, 1'b1, 8'hFF, 3'd0, 1'b0);
      else if (i == 20) drive(1'b0, 1'b1, 1'b0, 9'd0, 8'h00, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0);
      else              idle(1);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (dot !== e.dot || pri !== e.pri || opaque !== e.opaque || busy !== e.busy || wr_drop !== e.drop) begin
          n_fail++;
          $display("FAIL %s item %0d: got dot=%02h pri=%0d opq=%0b busy=%0b drop=%0b, want dot=%02h pri=%0d opq=%0b busy=%0b drop=%0b",
                   e.phase, item, dot, pri, opaque, busy, wr_drop, e.dot, e.pri, e.opaque, e.busy, e.drop);
        end
        item++;
      end
    end
  end

  initial begin
    clear_line();

    phase = "t1_reset";
    reset_seq();
    read_line(1'b1, 1'b0);

    phase = "t2_single";
    wr(9'd10, 8'h23, 3'd2, 1'b0);
    idle(3);
    line_dot[10] = 8'h23; line_pri[10] = 3'd2;
    read_line(1'b1, 1'b0);
    read_line(1'b1, 1'b0);
    read_line(1'b1, 1'b0);

    phase = "t3_priority";
    wr(9'd5, 8'h11, 3'd3, 1'b0);
    wr(9'd5, 8'h22, 3'd1, 1'b0);
    wr(9'd5, 8'h33, 3'd3, 1'b0);
    wr(9'd5, 8'hFF, 3'd7, 1'b0);
    wr(9'd7, 8'h66, 3'd1, 1'b0);
    wr(9'd7, 8'h77, 3'd4, 1'b0);
    wr(9'd6, 8'h44, 3'd4, 1'b0);
    idle(1);
    wr(9'd6, 8'h55, 3'd2, 1'b0);
    idle(3);
    line_dot[5] = 8'h33; line_pri[5] = 3'd3;
    line_dot[6] = 8'h44; line_pri[6] = 3'd4;
    line_dot[7] = 8'h77; line_pri[7] = 3'd4;
    read_line(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 9'd0, 8'h00, 3'd0, 1'b1, 8'hFF, 3'd0, 1'b0);

    phase = "t4_bounds";
    wr(9'd300, 8'h31, 3'd7, 1'b1);
    wr(9'd288, 8'h32, 3'd7, 1'b1);
    wr(9'd287, 8'h5A, 3'd1, 1'b0);
    wr(9'd0, 8'h01, 3'd0, 1'b0);
    idle(3);
    line_dot[287] = 8'h5A; line_pri[287] = 3'd1;
    line_dot[0]   = 8'h01; line_pri[0]   = 3'd0;
    read_line(1'b1, 1'b0);

    phase = "t5_swap_write";
    drive(1'b0, 1'b1, 1'b1, 9'd20, 8'h7C, 3'd5, 1'b0, 8'hFF, 3'd0, 1'b0);
    read_line(1'b0, 1'b0);
    line_dot[20] = 8'h7C; line_pri[20] = 3'd5;
    read_line(1'b1, 1'b0);

    phase = "t6_mid_reset";
    wr(9'd3, 8'h42, 3'd1, 1'b0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 9'd0, 8'h00, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, (i != 0), 9'd40, 8'h99, 3'd6, 1'b1,
            (i == 3) ? 8'h42 : 8'hFF, (i == 3) ? 3'd1 : 3'd0, 1'b0);
    reset_seq();
    read_line(1'b1, 1'b0);
    read_line(1'b1, 1'b0);

    phase = "drain";
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
